// File: rtl/pipeline_pkg.sv
// Shared pipeline types: opcodes, scoreboard entry, opcode classifiers.
// Imported by hazard_unit and multicycle_timer.
package pipeline_pkg;

  localparam int OP_CODE_LEN = 4;

  localparam logic [OP_CODE_LEN-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_CODE_LEN-1:0] OP_ADD  = 4'h1;
  localparam logic [OP_CODE_LEN-1:0] OP_SUB  = 4'h2;
  localparam logic [OP_CODE_LEN-1:0] OP_MUL  = 4'h3;
  localparam logic [OP_CODE_LEN-1:0] OP_DIV  = 4'h4;
  localparam logic [OP_CODE_LEN-1:0] OP_MOD  = 4'h5;
  localparam logic [OP_CODE_LEN-1:0] OP_MOVR = 4'h6;
  localparam logic [OP_CODE_LEN-1:0] OP_AND  = 4'h7;
  localparam logic [OP_CODE_LEN-1:0] OP_OR   = 4'h8;
  localparam logic [OP_CODE_LEN-1:0] OP_MOVI = 4'h9;
  localparam logic [OP_CODE_LEN-1:0] OP_LDR  = 4'hA;
  localparam logic [OP_CODE_LEN-1:0] OP_STR  = 4'hB;
  localparam logic [OP_CODE_LEN-1:0] OP_CMP  = 4'hC;
  localparam logic [OP_CODE_LEN-1:0] OP_BEQ  = 4'hD;
  localparam logic [OP_CODE_LEN-1:0] OP_JMP  = 4'hE;

  localparam int DIV_LATENCY_DEF = 8;

  // Widest register address a scoreboard entry can hold;
  // narrower addresses are zero-extended into it.
  localparam int SB_ADDR_W = 8;

  typedef struct packed {
    logic                 wr;
    logic [SB_ADDR_W-1:0] dest;
  } sb_entry_t;

  function automatic logic writes_reg(
    input logic [OP_CODE_LEN-1:0] op
  );
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV,
      OP_MOD, OP_MOVR, OP_AND, OP_OR,
      OP_MOVI, OP_LDR: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

  function automatic logic is_multicycle(
    input logic [OP_CODE_LEN-1:0] op
  );
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/multicycle_timer.sv
// Down-counter that keeps a multicycle op resident in EXE.
// Ports: clk, rst_n, start (op enters EXE), busy (count nonzero).
module multicycle_timer
  import pipeline_pkg::*;
#(
  parameter int LATENCY = DIV_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy
);

  localparam int CW =
    (LATENCY > 1) ? $clog2(LATENCY) : 1;
  // The entry cycle itself is the first EXE cycle,
  // so only LATENCY-1 extra cycles are counted.
  localparam logic [CW-1:0] LOAD = CW'(LATENCY - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_unit.sv
// RAW hazard detection over an EXE/MEM/WB write scoreboard plus
// multicycle EXE freeze. Ports: ID operands in; hazard/stall/busy/count out.
module hazard_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_LEN = 4,
  parameter int DIV_LATENCY  = DIV_LATENCY_DEF,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [OP_CODE_LEN-1:0]  id_opCode,
  input  logic [REG_ADDR_LEN-1:0] id_dest,
  input  logic [REG_ADDR_LEN-1:0] id_src1,
  input  logic [REG_ADDR_LEN-1:0] id_src2,
  input  logic                    id_src1_en,
  input  logic                    id_src2_en,
  output logic                    hazard_detected,
  output logic                    exe_stall,
  output logic                    div_busy,
  output logic [STALL_CNT_W-1:0]  stall_count
);

  sb_entry_t sb_exe;
  sb_entry_t sb_mem;
  sb_entry_t sb_wb;
  sb_entry_t exe_in;

  logic [SB_ADDR_W-1:0] src1;
  logic [SB_ADDR_W-1:0] src2;
  logic hit1;
  logic hit2;
  logic raw;
  logic issue;
  logic div_start;

  function automatic logic hit(
    input sb_entry_t            e,
    input logic [SB_ADDR_W-1:0] r
  );
    return e.wr && (e.dest == r);
  endfunction

  assign src1 = SB_ADDR_W'(id_src1);
  assign src2 = SB_ADDR_W'(id_src2);

  // No bypass: WB still counts because the
  // register file write lands at the end of WB.
  assign hit1 = hit(sb_exe, src1) |
                hit(sb_mem, src1) |
                hit(sb_wb, src1);
  assign hit2 = hit(sb_exe, src2) |
                hit(sb_mem, src2) |
                hit(sb_wb, src2);

  assign raw = id_valid &
               ((id_src1_en & hit1) |
                (id_src2_en & hit2));

  assign hazard_detected = raw | div_busy;
  assign exe_stall       = div_busy;

  assign issue     = id_valid & ~hazard_detected;
  assign div_start = issue & is_multicycle(id_opCode);

  assign exe_in.wr   = issue & writes_reg(id_opCode);
  assign exe_in.dest = SB_ADDR_W'(id_dest);

  multicycle_timer #(
    .LATENCY (DIV_LATENCY)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .busy  (div_busy)
  );

  // While EXE is frozen the held op stays put and
  // MEM receives a bubble behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_exe <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
    end else if (!exe_stall) begin
      sb_exe <= exe_in;
      sb_mem <= sb_exe;
      sb_wb  <= sb_mem;
    end else begin
      sb_mem <= '0;
      sb_wb  <= sb_mem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (hazard_detected &&
                 (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit.
// Two instances share ID inputs: 16-bit and 4-bit stall counters.
module tb_hazard_unit;
  import pipeline_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] id_opCode;
  logic [3:0] id_dest;
  logic [3:0] id_src1;
  logic [3:0] id_src2;
  logic       id_src1_en;
  logic       id_src2_en;

  logic        hazard_detected;
  logic        exe_stall;
  logic        div_busy;
  logic [15:0] stall_count;

  logic       s_hazard;
  logic       s_exe_stall;
  logic       s_busy;
  logic [3:0] s_count;

  int checks;
  int errors;

  hazard_unit #(
    .REG_ADDR_LEN (4),
    .DIV_LATENCY  (4),
    .STALL_CNT_W  (16)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_opCode       (id_opCode),
    .id_dest         (id_dest),
    .id_src1         (id_src1),
    .id_src2         (id_src2),
    .id_src1_en      (id_src1_en),
    .id_src2_en      (id_src2_en),
    .hazard_detected (hazard_detected),
    .exe_stall       (exe_stall),
    .div_busy        (div_busy),
    .stall_count     (stall_count)
  );

  hazard_unit #(
    .REG_ADDR_LEN (4),
    .DIV_LATENCY  (4),
    .STALL_CNT_W  (4)
  ) u_sat (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_opCode       (id_opCode),
    .id_dest         (id_dest),
    .id_src1         (id_src1),
    .id_src2         (id_src2),
    .id_src1_en      (id_src1_en),
    .id_src2_en      (id_src2_en),
    .hazard_detected (s_hazard),
    .exe_stall       (s_exe_stall),
    .div_busy        (s_busy),
    .stall_count     (s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic setid(
    input logic       v,
    input logic [3:0] op,
    input logic [3:0] d,
    input logic [3:0] a,
    input logic       ae,
    input logic [3:0] b,
    input logic       be
  );
    id_valid   = v;
    id_opCode  = op;
    id_dest    = d;
    id_src1    = a;
    id_src1_en = ae;
    id_src2    = b;
    id_src2_en = be;
  endtask

  task automatic idle();
    setid(1'b0, OP_NOP, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    setid(1'b1, OP_ADD, 4'd1, 4'd0, 1'b1, 4'd0, 1'b1);
    #12;
    checks++;
    if (hazard_detected !== 1'b0) begin
      errors++;
      $display("FAIL rst_hazard: got %b want 0", hazard_detected);
    end
    checks++;
    if (exe_stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_exe_stall: got %b want 0", exe_stall);
    end
    checks++;
    if (div_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy: got %b want 0", div_busy);
    end
    checks++;
    if (stall_count !== 16'd0 || s_count !== 4'd0) begin
      errors++;
      $display("FAIL rst_count: got %0d/%0d want 0/0",
               stall_count, s_count);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_dependent();
    logic exp;
    do_reset();
    setid(1'b1, OP_ADD, 4'd1, 4'd2, 1'b1, 4'd3, 1'b1);
    @(negedge clk);
    checks++;
    if (hazard_detected !== 1'b0) begin
      errors++;
      $display("FAIL dep_producer: got %b want 0", hazard_detected);
    end
    next_cycle();
    setid(1'b1, OP_ADD, 4'd2, 4'd1, 1'b1, 4'd3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp = (i < 3);
      checks++;
      if (hazard_detected !== exp) begin
        errors++;
        $display("FAIL dep_hz[%0d]: got %b want %b",
                 i, hazard_detected, exp);
      end
      if (i == 3) begin
        checks++;
        if (stall_count !== 16'd3) begin
          errors++;
          $display("FAIL dep_count: got %0d want 3", stall_count);
        end
      end
      next_cycle();
    end
    setid(1'b1, OP_ADD, 4'd3, 4'd2, 1'b1, 4'd4, 1'b0);
    @(negedge clk);
    checks++;
    if (hazard_detected !== 1'b1) begin
      errors++;
      $display("FAIL dep_consumer_in_exe: got %b want 1",
               hazard_detected);
    end
    next_cycle();
    idle();
  endtask

  task automatic test_independent();
    logic [3:0] ops [3];
    ops[0] = OP_ADD;
    ops[1] = OP_SUB;
    ops[2] = OP_AND;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      setid(1'b1, ops[i], 4'(i + 1),
            4'(4 + i), 1'b1, 4'(4 + ((i + 1) % 3)), 1'b1);
      @(negedge clk);
      checks++;
      if (hazard_detected !== 1'b0) begin
        errors++;
        $display("FAIL indep_hz[%0d]: got %b want 0",
                 i, hazard_detected);
      end
      next_cycle();
    end
    idle();
    @(negedge clk);
    checks++;
    if (stall_count !== 16'd0) begin
      errors++;
      $display("FAIL indep_count: got %0d want 0", stall_count);
    end
    next_cycle();
  endtask

  task automatic test_non_writers();
    logic [3:0] op [8];
    logic [3:0] d  [8];
    logic [3:0] a  [8];
    logic       ae [8];
    logic       exp;
    do_reset();
    op[0] = OP_CMP;  d[0] = 4'd1;  a[0] = 4'd4; ae[0] = 1'b1;
    op[1] = OP_ADD;  d[1] = 4'd2;  a[1] = 4'd1; ae[1] = 1'b1;
    op[2] = OP_STR;  d[2] = 4'd7;  a[2] = 4'd7; ae[2] = 1'b1;
    op[3] = OP_LDR;  d[3] = 4'd10; a[3] = 4'd7; ae[3] = 1'b1;
    op[4] = 4'hF;    d[4] = 4'd5;  a[4] = 4'd0; ae[4] = 1'b0;
    op[5] = OP_ADD;  d[5] = 4'd6;  a[5] = 4'd5; ae[5] = 1'b1;
    op[6] = OP_MOVI; d[6] = 4'd9;  a[6] = 4'd0; ae[6] = 1'b0;
    op[7] = OP_ADD;  d[7] = 4'd11; a[7] = 4'd9; ae[7] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      setid(1'b1, op[i], d[i], a[i], ae[i], 4'd8, 1'b0);
      @(negedge clk);
      exp = (i == 7);
      checks++;
      if (hazard_detected !== exp) begin
        errors++;
        $display("FAIL nonwr_hz[%0d]: got %b want %b",
                 i, hazard_detected, exp);
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_div_indep();
    logic exp;
    do_reset();
    setid(1'b1, OP_DIV, 4'd1, 4'd2, 1'b1, 4'd3, 1'b1);
    @(negedge clk);
    checks++;
    if (hazard_detected !== 1'b0 || div_busy !== 1'b0) begin
      errors++;
      $display("FAIL div_entry: got hz=%b busy=%b want 0/0",
               hazard_detected, div_busy);
    end
    next_cycle();
    setid(1'b1, OP_ADD, 4'd5, 4'd6, 1'b1, 4'd7, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      exp = (i < 4);
      checks++;
      if (hazard_detected !== exp || exe_stall !== exp ||
          div_busy !== exp) begin
        errors++;
        $display("FAIL div_busy[%0d]: got hz=%b st=%b bz=%b want %b",
                 i, hazard_detected, exe_stall, div_busy, exp);
      end
      next_cycle();
    end
    idle();
    @(negedge clk);
    checks++;
    if (stall_count !== 16'd3) begin
      errors++;
      $display("FAIL div_count: got %0d want 3", stall_count);
    end
    next_cycle();
  endtask

  task automatic test_div_dep();
    logic exp;
    do_reset();
    setid(1'b1, OP_DIV, 4'd1, 4'd2, 1'b1, 4'd3, 1'b1);
    next_cycle();
    setid(1'b1, OP_ADD, 4'd2, 4'd1, 1'b1, 4'd3, 1'b1);
    // 3 busy cycles, then DIV seen in EXE, MEM, WB.
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      exp = (i < 7);
      checks++;
      if (hazard_detected !== exp) begin
        errors++;
        $display("FAIL divdep_hz[%0d]: got %b want %b",
                 i, hazard_detected, exp);
      end
      if (i == 4) begin
        checks++;
        if (div_busy !== 1'b0) begin
          errors++;
          $display("FAIL divdep_busy_end: got %b want 0", div_busy);
        end
      end
      if (i == 7) begin
        checks++;
        if (stall_count !== 16'd6) begin
          errors++;
          $display("FAIL divdep_count: got %0d want 6", stall_count);
        end
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    setid(1'b1, OP_DIV, 4'd1, 4'd0, 1'b0, 4'd0, 1'b0);
    next_cycle();
    setid(1'b1, OP_ADD, 4'd2, 4'd1, 1'b1, 4'd3, 1'b1);
    next_cycle();
    @(negedge clk);
    checks++;
    if (div_busy !== 1'b1 || stall_count !== 16'd1) begin
      errors++;
      $display("FAIL rmid_pre: got busy=%b cnt=%0d want 1/1",
               div_busy, stall_count);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (hazard_detected !== 1'b0 || exe_stall !== 1'b0 ||
        div_busy !== 1'b0 || stall_count !== 16'd0) begin
      errors++;
      $display("FAIL rmid_async: got hz=%b st=%b bz=%b cnt=%0d want 0",
               hazard_detected, exe_stall, div_busy, stall_count);
    end
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (hazard_detected !== 1'b0 || stall_count !== 16'd0) begin
      errors++;
      $display("FAIL rmid_after: got hz=%b cnt=%0d want 0/0",
               hazard_detected, stall_count);
    end
    next_cycle();
    idle();
  endtask

  task automatic test_saturate();
    logic exp;
    do_reset();
    setid(1'b1, OP_DIV, 4'd1, 4'd0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      exp = ((i % 4) != 0);
      checks++;
      if (s_hazard !== exp) begin
        errors++;
        $display("FAIL sat_hz[%0d]: got %b want %b", i, s_hazard, exp);
      end
      next_cycle();
    end
    idle();
    @(negedge clk);
    checks++;
    if (s_count !== 4'd15) begin
      errors++;
      $display("FAIL sat_count4: got %0d want 15", s_count);
    end
    checks++;
    if (stall_count !== 16'd21) begin
      errors++;
      $display("FAIL sat_count16: got %0d want 21", stall_count);
    end
    checks++;
    if (s_busy !== 1'b0 || s_exe_stall !== 1'b0) begin
      errors++;
      $display("FAIL sat_idle: got bz=%b st=%b want 0/0",
               s_busy, s_exe_stall);
    end
    next_cycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    test_reset();
    test_dependent();
    test_independent();
    test_non_writers();
    test_div_indep();
    test_div_dep();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
